am_lock_fsm: RTL and testbench
==============================

Name: am_lock_fsm

Overview:
- Per-lane receive-side alignment-marker lock block for the 100GbE PCS (Clause 82), one instance per PCS lane.
- Sits after the lane's 66b block synchronizer and ahead of lane deskew/reorder.
- Finds the periodic AM inserted by the transmit path and identifies which of the 20 PCS lanes the physical lane carries.
- Declares AM lock and flags each AM block for downstream removal; drops lock after repeated bad AMs.

Parameters:
- NB_DATA_CODED, 66, coded block width; [65:64] is the sync header, [63:0] the payload.
- N_LANES, 20, number of PCS lanes (entries in the AM compare table).
- NB_LANE_ID, 5, width of the lane index output.
- AM_BLOCK_PERIOD, 16383, data blocks between consecutive AMs on a lane; an AM is expected on the (AM_BLOCK_PERIOD+1)th valid block after the previous AM.
- N_INVALID, 4, consecutive bad AMs while locked that cause loss of lock.

Ports:
- i_clock  in  1  block clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_enable  in  1  block enable; low = state frozen, outputs held, pulses forced 0.
- i_valid  in  1  qualifies i_data; only valid cycles advance the FSM and counters.
- i_block_lock  in  1  block-sync lock from the lane synchronizer.
- i_data  in  66  received coded block.
- o_lock  out  1  AM lock achieved.
- o_lane_id  out  5  PCS lane number of the locked or candidate AM.
- o_am_flag  out  1  1-cycle pulse: the current block was accepted as an AM.
- o_resync  out  1  1-cycle pulse on loss of AM lock.
- o_am_err_count  out  16  bad-AM counter (see Optional Feature).

Behaviour:
- Reset (i_reset=0, async): state RESET; all outputs 0; period counter 0; bad-AM counter 0; o_lane_id 0.
- All outputs are registered, so a response appears 1 cycle after the valid block that caused it.
- AM match is combinational on i_data and requires all of:
  - i_data[65:64]==2'b10;
  - M0/M1/M2 (bits [63:56]/[55:48]/[47:40]) equal table entry k;
  - M4/M5/M6 (bits [31:24]/[23:16]/[15:8]) equal the bitwise inverse of M0/M1/M2.
  - Bits [39:32] and [7:0] (BIP3, BIP7) are ignored.
- The table holds the Clause 82 lane AMs (Table 82-2), e.g. lane0 C1/68/21, lane1 9D/71/8E, lane2 59/4B/E8.
- i_block_lock=0 in any state: next cycle the state goes to RESET. If o_lock was 1, o_lock clears and o_resync pulses.
- FSM states and transitions:
  - RESET: when i_block_lock=1 -> FIND.
  - FIND: on a valid block matching lane k -> o_lane_id=k, counter=0, o_am_flag pulse, -> CHECK. Non-matching blocks -> stay in FIND.
  - CHECK: each valid block increments the counter. The block with counter==AM_BLOCK_PERIOD is the expected AM position; blocks before it are never compared (spurious AMs are ignored). At the expected position:
    - Match with the same lane k: o_am_flag pulse, counter=0, bad count=0; if unlocked, o_lock=1 (two consecutive good AMs give lock).
    - Mismatch while unlocked: -> FIND. If the block is itself a valid AM of another lane j, it immediately becomes the new candidate (o_lane_id=j, counter=0, o_am_flag pulse, stay in CHECK).
    - Mismatch while locked: bad count +1, counter=0, no o_am_flag. When bad count reaches N_INVALID: o_lock=0, o_resync pulse, -> FIND.
- Counter width is $clog2(AM_BLOCK_PERIOD+1) and it never wraps past AM_BLOCK_PERIOD. Cycles with i_valid=0 change nothing.
- o_lane_id holds its value after loss of lock until the next candidate is accepted.

Optional Feature:
- Macro AM_LOCK_ERR_CNT_EN.
- Defined: o_am_err_count counts mismatches at expected AM positions while o_lock=1. It saturates at 16'hFFFF and clears only on reset.
- Undefined: o_am_err_count is tied to 0 and no counter logic is built.

Test Plan:
- All sims use AM_BLOCK_PERIOD=7 and N_INVALID=4.
- Reset and idle: i_reset=0, then release with random data and no AMs -> o_lock=0, o_am_flag never set, o_lane_id=0.
- Lock acquire: lane1 AM, 7 data blocks, lane1 AM -> o_am_flag pulses 1 cycle after each AM; o_lock=1 and o_lane_id=1 one cycle after the second AM.
- Candidate replaced: lane0 AM, 7 data blocks, lane2 AM -> no lock, o_lane_id=2. Then 7 data blocks and lane2 AM -> o_lock=1.
- Lock loss:
  - While locked: 3 bad AMs then a good one -> o_lock stays 1; with macro, err_count=3.
  - Then 4 consecutive bad AMs -> o_lock=0 and o_resync pulses once, 1 cycle after the 4th; err_count=7.
- i_valid gaps: while locked, insert 1-3 idle cycles between valid blocks -> lock holds, and AMs are accepted only on the 8th valid block.
- Disturbances:
  - Drop i_block_lock while locked -> o_lock=0 and o_resync pulse next cycle; re-acquire needs two AMs.
  - Assert i_reset mid-CHECK -> all outputs 0 immediately.

Source files
------------

// File: rtl/am_lock_fsm.sv
// am_lock_fsm: per-lane Clause 82 alignment-marker lock FSM; define AM_LOCK_ERR_CNT_EN to build the bad-AM counter.
module am_lock_fsm #(
    parameter int NB_DATA_CODED   = 66,
    parameter int N_LANES         = 20,
    parameter int NB_LANE_ID      = 5,
    parameter int AM_BLOCK_PERIOD = 16383,
    parameter int N_INVALID       = 4
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_enable,
    input  logic                     i_valid,
    input  logic                     i_block_lock,
    input  logic [NB_DATA_CODED-1:0] i_data,
    output logic                     o_lock,
    output logic [NB_LANE_ID-1:0]    o_lane_id,
    output logic                     o_am_flag,
    output logic                     o_resync,
    output logic [15:0]              o_am_err_count
);
    localparam int NB_CNT = $clog2(AM_BLOCK_PERIOD + 1);
    localparam int NB_BAD = $clog2(N_INVALID + 1);

    typedef enum logic [1:0] {S_RESET, S_FIND, S_CHECK} state_t;

    state_t              state, state_next;
    logic [NB_CNT-1:0]   cnt, cnt_next;
    logic [NB_BAD-1:0]   bad, bad_next;
    logic [NB_LANE_ID-1:0] lane_next;
    logic                lock_next, flag_next, resync_next;
    logic                am_hit, am_valid, am_good, at_exp;
    logic [NB_LANE_ID-1:0] am_idx;
    logic                unused_bip;

    function automatic logic [23:0] am_code(input int k);
        case (k)
            0:  return 24'hC16821;
            1:  return 24'h9D718E;
            2:  return 24'h594BE8;
            3:  return 24'h4D957B;
            4:  return 24'hF50709;
            5:  return 24'hDD14C2;
            6:  return 24'h9A4A26;
            7:  return 24'h7B4566;
            8:  return 24'hA02476;
            9:  return 24'h68C9FB;
            10: return 24'hFD6C99;
            11: return 24'hB99155;
            12: return 24'h5CB9B2;
            13: return 24'h1AF8BD;
            14: return 24'h83C7CA;
            15: return 24'h3536CD;
            16: return 24'hC4314C;
            17: return 24'hADD6B7;
            18: return 24'h5F662A;
            19: return 24'hC0F0E5;
            default: return 24'h000000;
        endcase
    endfunction

    // BIP3 and BIP7 carry parity, not marker identity
    assign unused_bip = ^{i_data[39:32], i_data[7:0]};

    always_comb begin
        am_hit = 1'b0;
        am_idx = '0;
        for (int k = 0; k < N_LANES; k++) begin
            if (!am_hit && i_data[63:40] == am_code(k)) begin
                am_hit = 1'b1;
                am_idx = NB_LANE_ID'(k);
            end
        end
    end

    assign am_valid = am_hit && i_data[65:64] == 2'b10 && i_data[31:8] == ~i_data[63:40];
    assign am_good  = am_valid && am_idx == o_lane_id;
    assign at_exp   = cnt == NB_CNT'(AM_BLOCK_PERIOD);

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state     <= S_RESET;
            cnt       <= '0;
            bad       <= '0;
            o_lane_id <= '0;
            o_lock    <= 1'b0;
            o_am_flag <= 1'b0;
            o_resync  <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            bad       <= bad_next;
            o_lane_id <= lane_next;
            o_lock    <= lock_next;
            o_am_flag <= flag_next;
            o_resync  <= resync_next;
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        bad_next    = bad;
        lane_next   = o_lane_id;
        lock_next   = o_lock;
        flag_next   = 1'b0;
        resync_next = 1'b0;
        if (i_enable) begin
            if (!i_block_lock) begin
                state_next  = S_RESET;
                lock_next   = 1'b0;
                resync_next = o_lock;
                bad_next    = '0;
            end else if (i_valid) begin
                case (state)
                    S_RESET: state_next = S_FIND;
                    S_FIND: begin
                        if (am_valid) begin
                            lane_next  = am_idx;
                            cnt_next   = '0;
                            bad_next   = '0;
                            flag_next  = 1'b1;
                            state_next = S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        if (!at_exp) begin
                            cnt_next = cnt + 1'b1;
                        end else if (am_good) begin
                            cnt_next  = '0;
                            bad_next  = '0;
                            flag_next = 1'b1;
                            lock_next = 1'b1;
                        end else if (!o_lock) begin
                            // an AM of another lane replaces the candidate directly
                            if (am_valid) begin
                                lane_next = am_idx;
                                cnt_next  = '0;
                                flag_next = 1'b1;
                            end else begin
                                state_next = S_FIND;
                            end
                        end else begin
                            cnt_next = '0;
                            if (bad == NB_BAD'(N_INVALID - 1)) begin
                                bad_next    = '0;
                                lock_next   = 1'b0;
                                resync_next = 1'b1;
                                state_next  = S_FIND;
                            end else begin
                                bad_next = bad + 1'b1;
                            end
                        end
                    end
                    default: state_next = S_RESET;
                endcase
            end
        end
    end

`ifdef AM_LOCK_ERR_CNT_EN
    logic [15:0] err_cnt;
    logic        err_inc;

    assign err_inc = i_enable && i_block_lock && i_valid && state == S_CHECK
                     && at_exp && o_lock && !am_good;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset)
            err_cnt <= '0;
        else if (err_inc && err_cnt != 16'hFFFF)
            err_cnt <= err_cnt + 16'd1;
    end

    assign o_am_err_count = err_cnt;
`else
    assign o_am_err_count = 16'd0;
`endif

endmodule

// File: tb/tb_am_lock_fsm.sv
// tb_am_lock_fsm: scoreboard bench for am_lock_fsm with AM_BLOCK_PERIOD=7, N_INVALID=4.
module tb_am_lock_fsm;
    logic        clk, rst_n, en, valid, blk_lock;
    logic [65:0] data;
    logic        lock, flag, resync;
    logic [4:0]  lane;
    logic [15:0] err;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        lock;
        logic [4:0]  lane;
        logic        flag;
        logic        resync;
        logic [15:0] err;
    } exp_t;

    exp_t        sb[$];
    logic        e_lock = 1'b0;
    logic [4:0]  e_lane = '0;
    logic [15:0] e_err  = '0;

    localparam logic [23:0] AM_TAB [20] = '{
        24'hC16821, 24'h9D718E, 24'h594BE8, 24'h4D957B, 24'hF50709,
        24'hDD14C2, 24'h9A4A26, 24'h7B4566, 24'hA02476, 24'h68C9FB,
        24'hFD6C99, 24'hB99155, 24'h5CB9B2, 24'h1AF8BD, 24'h83C7CA,
        24'h3536CD, 24'hC4314C, 24'hADD6B7, 24'h5F662A, 24'hC0F0E5};

    am_lock_fsm #(.AM_BLOCK_PERIOD(7), .N_INVALID(4)) dut (
        .i_clock(clk), .i_reset(rst_n), .i_enable(en), .i_valid(valid),
        .i_block_lock(blk_lock), .i_data(data), .o_lock(lock), .o_lane_id(lane),
        .o_am_flag(flag), .o_resync(resync), .o_am_err_count(err));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [65:0] rnd();
        return {2'b01, $urandom, $urandom};
    endfunction

    function automatic logic [65:0] am(input int l);
        logic [23:0] m = AM_TAB[l];
        logic [7:0]  b = 8'($urandom);
        return {2'b10, m, b, ~m, b};
    endfunction

    // kind 0: broken inverse field, kind 1: wrong sync header
    function automatic logic [65:0] am_bad(input int l, input int kind);
        logic [23:0] m = AM_TAB[l];
        return kind == 0 ? {2'b10, m, 8'h00, ~m ^ 24'h000100, 8'h00}
                         : {2'b01, m, 8'h00, ~m, 8'h00};
    endfunction

    task automatic blk(input logic [65:0] d, input logic v, input logic e, input logic bl,
                       input logic f, input logic r);
        @(negedge clk);
        data = d; valid = v; en = e; blk_lock = bl;
        sb.push_back('{e_lock, e_lane, f, r, e_err});
    endtask

    task automatic dat(input int n);
        for (int i = 0; i < n; i++) blk(rnd(), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic bump();
`ifdef AM_LOCK_ERR_CNT_EN
        e_err++;
`endif
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("lock", 32'(lock), 32'(e.lock));
            check("lane", 32'(lane), 32'(e.lane));
            check("am_flag", 32'(flag), 32'(e.flag));
            check("resync", 32'(resync), 32'(e.resync));
            check("err_cnt", 32'(err), 32'(e.err));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [65:0] bads [4];
        rst_n = 1'b1; en = 1'b1; valid = 1'b0; blk_lock = 1'b0; data = '0;
        #1 rst_n = 1'b0;
        #3;
        check("rst_lock", 32'(lock), 0);
        check("rst_lane", 32'(lane), 0);
        check("rst_flag", 32'(flag), 0);
        check("rst_resync", 32'(resync), 0);
        check("rst_err", 32'(err), 0);
        @(negedge clk);
        rst_n = 1'b1; blk_lock = 1'b1;

        dat(10);

        e_lane = 5'd1;
        blk(am(1), 1, 1, 1, 1, 0);
        dat(7);
        e_lock = 1'b1;
        blk(am(1), 1, 1, 1, 1, 0);

        for (int i = 0; i < 8; i++) begin
            for (int g = 0; g <= i % 3; g++) blk(am(1), 0, 1, 1, 0, 0);
            if (i == 7) blk(am(1), 1, 1, 1, 1, 0);
            else if (i == 3) blk(am(1), 1, 1, 1, 0, 0);
            else blk(rnd(), 1, 1, 1, 0, 0);
        end

        blk(am(1), 1, 0, 1, 0, 0);
        blk(am(1), 1, 0, 1, 0, 0);
        dat(7);
        blk(am(1), 1, 1, 1, 1, 0);

        bads[0] = am(5); bads[1] = am_bad(1, 0); bads[2] = am_bad(1, 1); bads[3] = rnd();
        for (int i = 0; i < 3; i++) begin
            dat(7);
            bump();
            blk(bads[i], 1, 1, 1, 0, 0);
        end
        dat(7);
        blk(am(1), 1, 1, 1, 1, 0);
        for (int i = 0; i < 4; i++) begin
            dat(7);
            bump();
            if (i == 3) e_lock = 1'b0;
            blk(bads[i], 1, 1, 1, 0, i == 3);
        end
        dat(1);

        e_lane = 5'd0;
        blk(am(0), 1, 1, 1, 1, 0);
        dat(7);
        e_lane = 5'd2;
        blk(am(2), 1, 1, 1, 1, 0);
        dat(7);
        e_lock = 1'b1;
        blk(am(2), 1, 1, 1, 1, 0);

        e_lock = 1'b0;
        blk(rnd(), 1, 1, 0, 0, 1);
        blk(rnd(), 1, 1, 0, 0, 0);
        blk(rnd(), 1, 1, 1, 0, 0);
        e_lane = 5'd3;
        blk(am(3), 1, 1, 1, 1, 0);
        dat(7);
        e_lock = 1'b1;
        blk(am(3), 1, 1, 1, 1, 0);
        dat(7);
        blk(am(3), 1, 1, 1, 1, 0);

        @(posedge clk);
        #3 rst_n = 1'b0;
        valid = 1'b0;
        #1;
        check("arst_lock", 32'(lock), 0);
        check("arst_lane", 32'(lane), 0);
        check("arst_flag", 32'(flag), 0);
        check("arst_resync", 32'(resync), 0);
        check("arst_err", 32'(err), 0);
        repeat (2) @(posedge clk);
        #2;
        check("sb_empty", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
